arr_skew_feeder: RTL and testbench
==================================

# arr_skew_feeder

Input-side feeder for the systolic array. It takes the serial 8-bit activation stream read out of activation memory by the array controller and gathers ROWS bytes into one column vector. It then launches that vector into the PE array with row r delayed r cycles, forming the diagonal wavefront. It sits between the controller's memory read port and the array's west edge.

## Interface
- ROWS, 16, number of PE rows (vector length, max skew depth); ≥2
- DW, 8, bits per element
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- enable  input  1  global advance; low freezes all state
- in_valid  input  1  in_data beat offered
- in_data  input  DW  activation byte
- in_last  input  1  with an accepted beat: close the vector early, zero-pad remaining rows
- flush  input  1  launch any partial vector, then drain the skew lines
- in_ready  output  1  beat accepted when in_valid & in_ready at posedge
- out_data  output  ROWS*DW  row r at bits [r*DW +: DW]
- out_valid  output  ROWS  per-row element valid
- fire  output  1  one-cycle pulse: a vector enters row 0
- busy  output  1  gather buffer non-empty or any out_valid pending
- done  output  1  one-cycle pulse when a flush drain completes

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE:
  - in_ready = enable.
  - First accepted beat → FILL.
  - flush with nothing buffered and skew empty → done the next cycle; stays IDLE.
- FILL:
  - in_ready = enable.
  - Beat i stored at gather index widx; widx increments.
- Vector close: accepted beat has widx == ROWS-1, or in_last = 1.
  - Indices widx+1..ROWS-1 are zero.
  - Vector is copied to the skew stage; widx resets to 0.
  - Gathering continues with no bubble; the gather buffer and skew lines are independent.
- Skew stage: row r is an r-deep shift chain (row 0 zero-deep, registered once at launch). Chains shift every enabled cycle and carry a valid bit alongside the data.
- flush accepted (in any state with enable = 1):
  - Same-cycle beat is accepted and included first.
  - A non-empty gather buffer is closed and zero-padded as for in_last.
  - → DRAIN.
- DRAIN:
  - in_ready = 0.
  - When all valid bits are clear: done pulses, → IDLE.
- enable = 0:
  - No state change; in_ready = 0; out_valid forced 0.
  - out_data holds its value; fire = 0.
- Reset: state IDLE, widx 0, all skew data and valid bits 0. Outputs in_ready, out_data, out_valid, fire, busy and done are all 0.

## Timing
- Closing beat accepted at edge k, enable held high:
  - fire is high in cycle k+1.
  - out_valid[r] is high, with that element on out_data row r, during cycle k+1+r.
- Back-to-back vectors at full rate (one vector per ROWS beats) give continuous out_valid on every row after warm-up.
- Short vectors closed by in_last can produce consecutive fires. Each keeps its own diagonal; there is no collision because each row chain is a pure pipeline.
- Flush drain:
  - Flush accepted at edge k with a vector launched at k+1: done is high in cycle k+ROWS+1.
  - Flush with no work pending: done is high in cycle k+1.
- Simultaneous in_last and flush on the same beat: a single vector launches, not an extra zero vector.
- Reset mid-operation discards gathered and in-flight data; no done is issued.
- widx is clog2(ROWS) bits and never wraps past ROWS-1.

## Configuration
- ARR_FEED_STATS_EN defined:
  - Adds output vec_cnt[15:0], the count of launched vectors (fire pulses).
  - Saturates at 16'hFFFF and clears on reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- ROWS=4: beats 1,2,3,4 at edges 0-3 → fire in cycle 4; row0=1 in cycle 4, row1=2 in cycle 5, row2=3 in cycle 6, row3=4 in cycle 7; each out_valid bit high exactly one cycle.
- ROWS=4: beats 5,6 with in_last on 6 → rows 0..3 emit 5,6,0,0 on the diagonal; next beat 9 starts a new vector at widx 0.
- ROWS=4: 12 beats streamed continuously → three fires 4 cycles apart, no in_ready deassertion, out_valid[3] continuous for 12 cycles.
- ROWS=4: beats 7,8 then flush → padded vector 7,8,0,0 launched; in_ready=0 during DRAIN; done pulses exactly at the last row3 element + 1 edge; state returns to IDLE.
- enable dropped for 3 cycles mid-diagonal → out_valid=0 and no shift during the gap; the sequence resumes unaltered afterward. rstn low mid-vector → all outputs 0 the next cycle, no done.
- With ARR_FEED_STATS_EN: 5 vectors → vec_cnt=5; force the counter near saturation → holds 16'hFFFF.

Source files
------------

// File: rtl/arr_skew_feeder.sv
// -----------------------------------------------------------------------------
// arr_skew_feeder
//   Input-side feeder for the systolic array. Gathers ROWS serial activation
//   bytes into one column vector, then launches the vector into the PE array
//   with row r delayed r cycles, forming the diagonal wavefront.
//
// Parameters
//   ROWS      number of PE rows (vector length, max skew depth), >= 2
//   DW        bits per element
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset
//   enable     global advance; low freezes all state
//   in_valid   activation beat offered
//   in_data    activation byte
//   in_last    with an accepted beat: close the vector early, zero-pad the rest
//   flush      launch any partial vector, then drain the skew lines
//   in_ready   beat accepted when in_valid & in_ready at posedge
//   out_data   row r element at [r*DW +: DW]
//   out_valid  per-row element valid
//   fire       one-cycle pulse: a vector enters row 0
//   busy       gather buffer non-empty or any skew valid pending
//   done       one-cycle pulse when a flush drain completes
//   vec_cnt    (ARR_FEED_STATS_EN only) saturating count of launched vectors
//
// Optional feature macro: ARR_FEED_STATS_EN
// -----------------------------------------------------------------------------
module arr_skew_feeder #(
  parameter int ROWS = 16,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  input  logic                 flush,
  output logic                 in_ready,
  output logic [ROWS*DW-1:0]   out_data,
  output logic [ROWS-1:0]      out_valid,
  output logic                 fire,
  output logic                 busy,
  output logic                 done
`ifdef ARR_FEED_STATS_EN
  ,
  output logic [15:0]          vec_cnt
`endif
);

  localparam int WW = $clog2(ROWS);
  localparam logic [WW-1:0] LAST_IDX = WW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [WW-1:0]   r_widx;
  logic [DW-1:0]   r_gbuf [ROWS];
  logic            r_done_pend;

  logic            w_acc;
  logic            w_flush;
  logic            w_close;
  logic            w_gbuf_empty;
  logic            w_any_valid;
  logic            w_idle_empty_flush;
  logic [ROWS-1:0] w_row_any;

  assign w_gbuf_empty = (r_widx == '0);
  assign w_any_valid  = |w_row_any;

  assign in_ready = enable & rstn & (r_state != S_DRAIN);
  assign w_acc    = in_valid & in_ready;
  assign w_flush  = flush & enable & rstn;

  // A flush folds into the same close as the beat it arrives with, so an
  // in_last+flush beat launches exactly one vector.
  assign w_close = (w_acc & (in_last | (r_widx == LAST_IDX)))
                 | (w_flush & (w_acc | ~w_gbuf_empty));

  // Flush in IDLE with nothing anywhere: answer with done one cycle later
  // without leaving IDLE (in_ready stays high).
  assign w_idle_empty_flush = (r_state == S_IDLE) & w_flush & ~w_acc
                            & w_gbuf_empty & ~w_any_valid;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_flush) begin
          if (!w_idle_empty_flush) w_state_nx = S_DRAIN;
        end else if (w_acc) begin
          w_state_nx = S_FILL;
        end
      end
      S_FILL: begin
        if (w_flush) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_any_valid) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_widx      <= '0;
      r_done_pend <= 1'b0;
      for (int unsigned i = 0; i < ROWS; i++) r_gbuf[i] <= '0;
    end else if (enable) begin
      r_state     <= w_state_nx;
      r_done_pend <= w_idle_empty_flush;
      if (w_close) begin
        // Clearing on close provides the zero padding for the next vector.
        r_widx <= '0;
        for (int unsigned i = 0; i < ROWS; i++) r_gbuf[i] <= '0;
      end else if (w_acc) begin
        r_gbuf[r_widx] <= in_data;
        r_widx         <= r_widx + 1'b1;
      end
    end
  end

  assign done = rstn & enable
              & (((r_state == S_DRAIN) & ~w_any_valid) | r_done_pend);

  // Skew lines: row r has a launch register followed by r shift stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [WW-1:0] RI = WW'(r);

    logic [DW-1:0] r_cd [r+1];
    logic [r:0]    r_cv;
    logic [DW-1:0] w_lane;

    // Element for this row at launch: the closing beat lands directly here.
    always_comb begin
      w_lane = r_gbuf[r];
      if (w_acc && (r_widx == RI)) w_lane = in_data;
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_cv <= '0;
        for (int unsigned s = 0; s <= r; s++) r_cd[s] <= '0;
      end else if (enable) begin
        r_cv[0] <= w_close;
        if (w_close) r_cd[0] <= w_lane;
        for (int unsigned s = 1; s <= r; s++) begin
          r_cv[s] <= r_cv[s-1];
          r_cd[s] <= r_cd[s-1];
        end
      end
    end

    assign w_row_any[r]           = |r_cv;
    assign out_valid[r]           = r_cv[r] & enable;
    assign out_data[r*DW +: DW]   = r_cd[r];
  end

  assign fire = out_valid[0];
  assign busy = ~w_gbuf_empty | w_any_valid;

`ifdef ARR_FEED_STATS_EN
  logic [15:0] r_vec_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vec_cnt <= '0;
    end else if (enable && w_close && (r_vec_cnt != '1)) begin
      r_vec_cnt <= r_vec_cnt + 16'd1;
    end
  end

  assign vec_cnt = r_vec_cnt;
`endif

endmodule

// File: tb/tb_arr_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_arr_skew_feeder
//   Scoreboard bench for arr_skew_feeder with ROWS=4. Each accepted closing
//   beat pushes one expected (row, enabled-cycle, data) entry per row; a
//   negedge monitor pops entries when their enabled-cycle number arrives and
//   checks out_valid/out_data/fire/done.
// -----------------------------------------------------------------------------
module tb_arr_skew_feeder;

  localparam int ROWS = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              enable = 1'b1;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic              flush = 1'b0;
  logic              in_ready;
  logic [ROWS*DW-1:0] out_data;
  logic [ROWS-1:0]   out_valid;
  logic              fire;
  logic              busy;
  logic              done;
`ifdef ARR_FEED_STATS_EN
  logic [15:0]       vec_cnt;
`endif

  arr_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .fire      (fire),
    .busy      (busy),
    .done      (done)
`ifdef ARR_FEED_STATS_EN
    ,
    .vec_cnt   (vec_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            row;
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;   // enabled, out-of-reset clock edges seen so far
  bit mon_on = 1'b0;

  // Reference model state
  logic [DW-1:0] mg [ROWS];
  int mw       = 0;
  bit m_fill   = 1'b0;
  bit m_drain  = 1'b0;
  int done_at  = -1;
  int last_cyc = -100;

  always @(posedge clk) if (rstn && enable) ecnt <= ecnt + 1;

  // Monitor
  logic [ROWS-1:0] mon_seen;
  bit              mon_fire;
  int              mon_r;

  always @(negedge clk) begin
    if (mon_on && rstn) begin
      if (!enable) begin
        checks++;
        if (out_valid !== '0 || fire !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL gated_outputs got valid=%b fire=%b done=%b want 0/0/0",
                   out_valid, fire, done);
        end
      end else begin
        mon_seen = '0;
        mon_fire = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].cyc == ecnt) begin
            mon_r = sb[i].row;
            mon_seen[mon_r] = 1'b1;
            if (mon_r == 0) mon_fire = 1'b1;
            checks++;
            if (out_valid[mon_r] !== 1'b1 || out_data[mon_r*DW +: DW] !== sb[i].d) begin
              errors++;
              $display("FAIL row%0d_elem at cyc %0d got v=%b d=%0h want v=1 d=%0h",
                       mon_r, ecnt, out_valid[mon_r], out_data[mon_r*DW +: DW], sb[i].d);
            end
            sb.delete(i);
          end else if (sb[i].cyc < ecnt) begin
            checks++;
            errors++;
            $display("FAIL row%0d_missed got nothing want %0h at cyc %0d",
                     sb[i].row, sb[i].d, sb[i].cyc);
            sb.delete(i);
          end
        end
        checks++;
        if (out_valid !== mon_seen) begin
          errors++;
          $display("FAIL valid_pattern at cyc %0d got %b want %b", ecnt, out_valid, mon_seen);
        end
        checks++;
        if (fire !== mon_fire) begin
          errors++;
          $display("FAIL fire at cyc %0d got %b want %b", ecnt, fire, mon_fire);
        end
        checks++;
        if (done !== (done_at == ecnt)) begin
          errors++;
          $display("FAIL done at cyc %0d got %b want %b", ecnt, done, (done_at == ecnt));
        end
      end
    end
  end

  task automatic model_clear();
    sb.delete();
    mw       = 0;
    m_fill   = 1'b0;
    m_drain  = 1'b0;
    done_at  = -1;
    last_cyc = -100;
  endtask

  // One clock cycle: inputs applied just after a posedge, ready checked at
  // the negedge, model advanced just after the following posedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic f);
    logic rdy;
    logic en;
    bit   exp_rdy, acc, fl, cls, was_drain, empty_idle;
    int   len, e;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    flush    = f;
    @(negedge clk);
    rdy = in_ready;
    en  = enable;
    exp_rdy = en && !m_drain;
    checks++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready at cyc %0d got %b want %b", ecnt, rdy, exp_rdy);
    end
    @(posedge clk);
    #1;
    e   = ecnt;
    acc = exp_rdy && v;
    fl  = f && en;
    was_drain = m_drain;
    empty_idle = !m_fill && !acc && (mw == 0) && (last_cyc < e - 1);
    cls = 1'b0;
    len = mw;
    if (acc) begin
      mg[mw] = d;
      len = mw + 1;
      if (mw == ROWS - 1 || l) cls = 1'b1;
    end
    if (fl && len > 0) cls = 1'b1;
    if (cls) begin
      for (int r = 0; r < ROWS; r++)
        sb.push_back('{row: r, cyc: e + r, d: (r < len) ? mg[r] : '0});
      last_cyc = e + ROWS - 1;
      mw = 0;
    end else if (acc) begin
      mw = mw + 1;
    end
    if (acc) m_fill = 1'b1;
    if (fl && !was_drain) begin
      if (empty_idle) begin
        done_at = e;
      end else begin
        m_drain = 1'b1;
        done_at = (last_cyc + 1 > e) ? last_cyc + 1 : e;
      end
    end
    if (m_drain && e > done_at) begin
      m_drain = 1'b0;
      m_fill  = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b0 || out_data !== '0 || out_valid !== '0 ||
        fire !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got rdy=%b data=%0h valid=%b fire=%b busy=%b done=%b want all 0",
               tag, in_ready, out_data, out_valid, fire, busy, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
    mon_on = 1'b1;
  endtask

  task automatic test_single_vector();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    idle(ROWS + 1);
  endtask

  task automatic test_short_vector();
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_gather got %b want 1", busy);
    end
    cycle(1'b1, 8'h06, 1'b1, 1'b0);
    cycle(1'b1, 8'h09, 1'b0, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    cycle(1'b1, 8'h0B, 1'b0, 1'b0);
    cycle(1'b1, 8'h0C, 1'b0, 1'b0);
    idle(ROWS + 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    idle(ROWS + 1);
  endtask

  task automatic test_consecutive_fires();
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h70 + i), 1'b1, 1'b0);
    cycle(1'b1, 8'h7A, 1'b0, 1'b0);
    cycle(1'b1, 8'h7B, 1'b1, 1'b0);
    idle(ROWS + 1);
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    cycle(1'b1, 8'h08, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Beats offered while draining must be refused.
    for (int i = 0; i < ROWS + 1; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_drain_idle got busy=%b rdy=%b want busy=0 rdy=1", busy, in_ready);
    end
    @(posedge clk);
    #1;
    if (rstn && enable) ; // edge consumed with inputs idle
  endtask

  task automatic test_flush_empty();
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_last_flush();
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b1, 1'b1);
    idle(ROWS + 3);
  endtask

  task automatic test_enable_gap();
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    idle(1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_frozen got %b want 1", busy);
    end
    enable = 1'b1;
    idle(ROWS + 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h31 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h35, 1'b0, 1'b1);
    mon_on = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_mid");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
    mon_on = 1'b1;
    idle(ROWS + 3);
  endtask

`ifdef ARR_FEED_STATS_EN
  task automatic test_stats();
    mon_on = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
    mon_on = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (vec_cnt !== 16'd5) begin
      errors++;
      $display("FAIL vec_cnt got %0d want 5", vec_cnt);
    end
    @(posedge clk);
    #1;
    force dut.r_vec_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.r_vec_cnt;
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h90 + i), 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (vec_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL vec_cnt_sat got %0h want ffff", vec_cnt);
    end
    @(posedge clk);
    #1;
    idle(ROWS + 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_vector();
    test_short_vector();
    test_back_to_back();
    test_consecutive_fires();
    test_flush();
    test_flush_empty();
    test_last_flush();
    test_enable_gap();
    test_reset_mid();
`ifdef ARR_FEED_STATS_EN
    test_stats();
`endif
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
